// File: rtl/clk_div_meter_if.sv
// Measurement bus of clk_div_meter: the divided clock going in, period/duty/lock status coming out.
interface clk_div_meter_if #(
  parameter int WIDTH = 16
);
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             timeout;

  modport master (
    output sig_in,
    input  period, high_time, meas_valid, locked, timeout
  );

  modport slave (
    input  sig_in,
    output period, high_time, meas_valid, locked, timeout
  );
endinterface

// File: rtl/clk_div_meter.sv
// Measures period, high time and lock state of a clk-synchronous divided clock.
// Define CLK_DIV_METER_DUTY_EN to build the high-time counter; otherwise high_time reads 0.
//
// state  | meaning
// S_IDLE | no reference rising edge seen yet (after reset or timeout)
// S_RUN  | counting clk cycles since the last rising edge
module clk_div_meter #(
  parameter int WIDTH    = 16,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 1000
) (
  input logic           clk,
  input logic           rst,
  clk_div_meter_if.slave bus
);
  localparam int              MW       = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] TMO      = WIDTH'(TIMEOUT);
  localparam logic [MW-1:0]    LOCK_MAX = MW'(LOCK_CNT);
  localparam logic [MW-1:0]    LOCK_PRE = MW'(LOCK_CNT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sig_q;
  logic             r_sig_qd;
  logic             w_edge;
  logic             w_tmo;
  logic             w_start;
  logic             w_meas;
  logic             w_expire;
  logic             w_count;
  logic             w_same;
  logic [WIDTH-1:0] r_per_cnt;
  logic [WIDTH-1:0] r_period;
  logic             r_meas_valid;
  logic             r_locked;
  logic             r_timeout;
  logic             r_first;
  logic [MW-1:0]    r_match_cnt;

  assign w_edge = r_sig_q & ~r_sig_qd;
  assign w_tmo  = (r_per_cnt == TMO);
  assign w_same = (r_per_cnt == r_period);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig_q  <= 1'b0;
      r_sig_qd <= 1'b0;
    end else begin
      r_sig_q  <= bus.sig_in;
      r_sig_qd <= r_sig_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_edge) w_state_nxt = S_RUN;
      S_RUN:   if (!w_edge && w_tmo) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // An edge always wins over an expiring counter, so period may equal TIMEOUT exactly.
  always_comb begin
    w_start  = 1'b0;
    w_meas   = 1'b0;
    w_expire = 1'b0;
    w_count  = 1'b0;
    case (r_state)
      S_IDLE: w_start = w_edge;
      S_RUN: begin
        w_meas   = w_edge;
        w_expire = !w_edge && w_tmo;
        w_count  = !w_edge && !w_tmo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_per_cnt    <= '0;
      r_period     <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_timeout    <= 1'b0;
      r_first      <= 1'b0;
      r_match_cnt  <= '0;
    end else begin
      r_meas_valid <= w_meas;
      if (w_start) begin
        r_per_cnt <= WIDTH'(1);
        r_first   <= 1'b1;
      end else if (w_meas) begin
        r_period  <= r_per_cnt;
        r_per_cnt <= WIDTH'(1);
        r_timeout <= 1'b0;
        r_first   <= 1'b0;
        // The first measurement after IDLE has nothing to compare against.
        if (r_first) begin
          r_match_cnt <= '0;
        end else if (w_same) begin
          if (r_match_cnt != LOCK_MAX) r_match_cnt <= r_match_cnt + 1'b1;
          if (r_match_cnt >= LOCK_PRE) r_locked <= 1'b1;
        end else begin
          r_match_cnt <= '0;
          r_locked    <= 1'b0;
        end
      end else if (w_expire) begin
        r_per_cnt   <= '0;
        r_timeout   <= 1'b1;
        r_locked    <= 1'b0;
        r_match_cnt <= '0;
      end else if (w_count) begin
        r_per_cnt <= r_per_cnt + 1'b1;
      end
    end
  end

`ifdef CLK_DIV_METER_DUTY_EN
  logic [WIDTH-1:0] r_high_cnt;
  logic [WIDTH-1:0] r_high_time;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_high_cnt  <= '0;
      r_high_time <= '0;
    end else if (w_start) begin
      r_high_cnt <= WIDTH'(1);
    end else if (w_meas) begin
      r_high_time <= r_high_cnt;
      r_high_cnt  <= WIDTH'(1);
    end else if (w_expire) begin
      r_high_cnt <= '0;
    end else if (w_count && r_sig_q) begin
      r_high_cnt <= r_high_cnt + 1'b1;
    end
  end

  assign bus.high_time = r_high_time;
`else
  assign bus.high_time = '0;
`endif

  assign bus.period     = r_period;
  assign bus.meas_valid = r_meas_valid;
  assign bus.locked     = r_locked;
  assign bus.timeout    = r_timeout;
endmodule

// File: tb/tb_clk_div_meter.sv
// Directed bench for clk_div_meter with TIMEOUT=20: period table, timeout, recovery and async reset.
module tb_clk_div_meter;
  localparam int WIDTH    = 16;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 20;
  localparam int NVEC     = 20;

  typedef struct {
    int   h;
    int   l;
    int   per;
    int   hi;
    logic lk;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] h;
    logic             l;
    logic             t;
  } meas_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    n_cmp = 0;
  int    n_err = 0;
  vec_t  tbl[NVEC];
  meas_t q[$];

  clk_div_meter_if #(.WIDTH(WIDTH)) bus ();

  clk_div_meter #(
    .WIDTH   (WIDTH),
    .LOCK_CNT(LOCK_CNT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.meas_valid === 1'b1) q.push_back('{bus.period, bus.high_time, bus.locked, bus.timeout});
  end

  function automatic int eh(input int h);
`ifdef CLK_DIV_METER_DUTY_EN
    return h;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_period(input int h, input int l);
    bus.sig_in = 1'b1;
    repeat (h) tick();
    bus.sig_in = 1'b0;
    repeat (l) tick();
  endtask

  // Rise sampled at edge P0: meas_valid is registered at P0+1 and reads 1 when sampled at P0+2.
  task automatic rise_check(input string nm, input int exp_per, input int exp_hi);
    bus.sig_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({nm, "_mv_early"}, bus.meas_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check({nm, "_mv"}, bus.meas_valid, 1);
    check({nm, "_period"}, bus.period, exp_per);
    check({nm, "_high"}, bus.high_time, eh(exp_hi));
    check({nm, "_timeout"}, bus.timeout, 0);
    @(posedge clk);
    #1;
    bus.sig_in = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    int tcyc;
    int n0;

    for (int i = 0; i < 6; i++)  tbl[i] = '{3, 2, 5, 3, (i >= 4)};
    tbl[6] = '{4, 3, 7, 4, 1'b0};
    for (int i = 7; i < 12; i++) tbl[i] = '{3, 2, 5, 3, (i == 11)};
    tbl[12] = '{1, 1, 2, 1, 1'b0};
    tbl[13] = '{2, 7, 9, 2, 1'b0};
    tbl[14] = '{10, 10, 20, 10, 1'b0};
    for (int i = 15; i < 20; i++) tbl[i] = '{3, 2, 5, 3, (i == 19)};

    bus.sig_in = 1'b0;
    repeat (2) tick();
    check("rst_period", bus.period, 0);
    check("rst_high", bus.high_time, 0);
    check("rst_mv", bus.meas_valid, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_timeout", bus.timeout, 0);
    rst = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < NVEC; i++) drive_period(tbl[i].h, tbl[i].l);

    // Final rise closes the last table period; holding high must then time out.
    bus.sig_in = 1'b1;
    tcyc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.timeout === 1'b1) begin
        tcyc = k;
        break;
      end
    end
    check("timeout_latency", tcyc, 22);
    check("timeout_locked", bus.locked, 0);
    check("timeout_period_hold", bus.period, 5);
    check("timeout_high_hold", bus.high_time, eh(3));
    check("meas_count", q.size(), NVEC);
    for (int i = 0; i < NVEC; i++) begin
      if (i < q.size()) begin
        check($sformatf("v%0d_period", i), q[i].p, tbl[i].per);
        check($sformatf("v%0d_high", i), q[i].h, eh(tbl[i].hi));
        check($sformatf("v%0d_locked", i), q[i].l, tbl[i].lk);
        check($sformatf("v%0d_timeout", i), q[i].t, 0);
      end
    end

    bus.sig_in = 1'b0;
    repeat (3) tick();
    n0 = q.size();
    drive_period(3, 2);
    check("idle_first_rise_no_mv", q.size(), n0);
    check("idle_timeout_sticky", bus.timeout, 1);
    rise_check("recover", 5, 3);

    repeat (4) drive_period(3, 2);
    check("relock_before_rst", bus.locked, 1);
    bus.sig_in = 1'b1;
    tick();
    #2;
    n0 = q.size();
    rst = 1'b1;
    #1;
    check("arst_period", bus.period, 0);
    check("arst_high", bus.high_time, 0);
    check("arst_mv", bus.meas_valid, 0);
    check("arst_locked", bus.locked, 0);
    check("arst_timeout", bus.timeout, 0);
    repeat (2) tick();
    bus.sig_in = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    drive_period(3, 2);
    check("post_rst_no_mv", q.size(), n0);
    rise_check("post_rst", 5, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/clk_div_meter.md
CLK_DIV_METER -- requirements
Module: clk_div_meter

Interface
REQ-001 Parameter WIDTH, default 16, bit width of the period and high-time counters and outputs.
REQ-002 Parameter LOCK_CNT, default 4, number of consecutive equal-period measurements required to assert locked.
REQ-003 Parameter TIMEOUT, default 1000, period count at which a missing rising edge is declared; SHALL satisfy 2 <= TIMEOUT < 2^WIDTH.
REQ-004 clk  input  1  sole clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 sig_in  input  1  divided clock under measurement, synchronous to clk.
REQ-007 period  output  WIDTH  last measured rising-edge-to-rising-edge interval, in clk cycles.
REQ-008 high_time  output  WIDTH  clk cycles sig_in was high within the last measured period.
REQ-009 meas_valid  output  1  one-cycle pulse when period and high_time update.
REQ-010 locked  output  1  level; period is stable.
REQ-011 timeout  output  1  sticky level; no rising edge arrived within TIMEOUT cycles.

Function
REQ-012 sig_in SHALL be registered once (sig_q), then again (sig_qd); rising edge = sig_q & ~sig_qd.
REQ-013 The FSM SHALL have two states: IDLE (no reference edge yet) and RUN (counting since the last edge).
REQ-014 IDLE: on a rising edge, go to RUN, set per_cnt=1 and high_cnt=1, and do not pulse meas_valid.
REQ-015 RUN, no edge: per_cnt increments by 1; high_cnt increments when sig_q=1.
REQ-016 RUN, edge: period<=per_cnt, high_time<=high_cnt, meas_valid=1 for one cycle, per_cnt<=1, high_cnt<=1, timeout<=0.
REQ-017 Latency: meas_valid SHALL assert 2 clk cycles after the sampling edge at which sig_in first reads 1.
REQ-018 Lock: each measurement SHALL compare against the previous one. If equal, match_cnt increments, saturating at LOCK_CNT; otherwise match_cnt<=0 and locked<=0.
REQ-019 locked SHALL assert in the same cycle as the meas_valid that brings match_cnt to LOCK_CNT.
REQ-020 The first measurement after IDLE SHALL have no predecessor: match_cnt<=0 and no compare.
REQ-021 Timeout: in RUN, when per_cnt==TIMEOUT and no edge occurs this cycle, go to IDLE, timeout<=1, locked<=0, match_cnt<=0; period and high_time hold.
REQ-022 Simultaneous edge and per_cnt==TIMEOUT: the edge wins and the measurement is taken per REQ-016 with period=TIMEOUT.
REQ-023 per_cnt and high_cnt SHALL never wrap, guaranteed by REQ-003 and REQ-021.
REQ-024 A constant-high or constant-low sig_in in RUN SHALL produce a timeout, never a measurement.

Reset
REQ-025 While rst=1: state=IDLE, period=0, high_time=0, meas_valid=0, locked=0, timeout=0, match_cnt=0, per_cnt=0, high_cnt=0, sig_q=0, sig_qd=0.
REQ-026 Reset asserted mid-measurement SHALL abort it with no meas_valid; after release, the first rising edge re-enters RUN per REQ-014.

Configuration
REQ-027 Macro CLK_DIV_METER_DUTY_EN defined: high_cnt and high_time SHALL be implemented per REQ-015 and REQ-016.
REQ-028 Macro CLK_DIV_METER_DUTY_EN undefined: no high_cnt register, high_time tied to 0, all other behaviour unchanged.

Verification
REQ-029 Repeating sig_in pattern 3 high / 2 low (divide-by-5) -> every meas_valid has period=5 and high_time=3; locked rises at the 5th meas_valid.
REQ-030 Reset release, then first sig_in rise -> no meas_valid; second rise -> meas_valid exactly 2 cycles after that sample, with period=5.
REQ-031 Locked on divide-by-5, then one period of 7 -> locked drops with that meas_valid (period=7); it re-locks after 4 further equal periods.
REQ-032 TIMEOUT=20, sig_in held low after an edge -> timeout=1 at per_cnt=20, locked=0, state IDLE; next two rises -> one meas_valid, timeout=0.
REQ-033 TIMEOUT=20, rising edge arriving exactly at per_cnt=20 -> meas_valid with period=20 and timeout stays 0.
REQ-034 rst pulsed mid-period while locked -> all outputs 0 immediately (asynchronous), no spurious meas_valid; build without CLK_DIV_METER_DUTY_EN -> high_time=0 throughout.
